// File: rtl/and_or_bist_ctrl.sv
// and_or_bist_ctrl: built-in self-test sequencer for one and_or cell (e = (a&b)|(c&d)).
// Sweeps every input vector, holds it SETTLE_CYCLES cycles, samples e, builds the
// captured truth table and counts mismatches against EXP_TABLE.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active low
//   start      in   sweep request, only honoured in IDLE
//   dut_in     out  {a,b,c,d} driven into the cell
//   dut_out    in   e from the cell
//   busy       out  sweep in progress (DRIVE/SAMPLE/DONE)
//   done       out  one-cycle completion pulse
//   pass       out  captured table equals EXP_TABLE
//   table_out  out  captured truth table, bit i = e for vector i
//   fail_cnt   out  number of mismatching vectors
//   fail_idx   out  first failing vector (only with AND_OR_BIST_STOP_ON_FAIL_EN)
//
// Optional build macro: AND_OR_BIST_STOP_ON_FAIL_EN -- stop at the first mismatch
// and report its index on fail_idx.
module and_or_bist_ctrl #(
  parameter int unsigned               N_IN          = 4,
  parameter int unsigned               SETTLE_CYCLES = 2,
  parameter logic [(1 << N_IN) - 1:0]  EXP_TABLE     = 16'hF888
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [N_IN-1:0]          dut_in,
  input  logic                     dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [(1 << N_IN) - 1:0] table_out,
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
  output logic [N_IN-1:0]          fail_idx,
`endif
  output logic [N_IN:0]            fail_cnt
);

  localparam int unsigned NVEC  = 1 << N_IN;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [N_IN:0]       idx_q, idx_d;      // one extra bit so the last-vector compare never wraps
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_IN-1:0]     dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [NVEC-1:0]     table_q, table_d;
  logic [N_IN:0]       fail_cnt_q, fail_cnt_d;
  logic                mismatch_c;
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
  logic [N_IN-1:0]     fail_idx_q, fail_idx_d;
`endif

  assign mismatch_c = (dut_out != EXP_TABLE[idx_q[N_IN-1:0]]);

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      table_q    <= '0;
      fail_cnt_q <= '0;
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
      fail_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dut_in_q   <= dut_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      table_q    <= table_d;
      fail_cnt_q <= fail_cnt_d;
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
      fail_idx_q <= fail_idx_d;
`endif
    end
  end

  // Next-state and registered-output logic; outputs take the value of the state being entered
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    table_d    = table_q;
    fail_cnt_d = fail_cnt_q;
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
    fail_idx_d = fail_idx_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        dut_in_d = '0;
        busy_d   = 1'b0;
        if (start) begin
          state_d    = S_DRIVE;
          idx_d      = '0;
          cnt_d      = '0;
          table_d    = '0;
          fail_cnt_d = '0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
          fail_idx_d = '0;
`endif
        end
      end

      S_DRIVE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        table_d[idx_q[N_IN-1:0]] = dut_out;
        if (mismatch_c) fail_cnt_d = fail_cnt_q + (N_IN+1)'(1);
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
        if (mismatch_c) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          pass_d     = 1'b0;
          dut_in_d   = '0;
          fail_idx_d = idx_q[N_IN-1:0];
        end else
`endif
        if (idx_q == (N_IN+1)'(NVEC - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          pass_d   = (fail_cnt_d == '0);
          dut_in_d = '0;
        end else begin
          idx_d    = idx_q + (N_IN+1)'(1);
          dut_in_d = idx_d[N_IN-1:0];
          state_d  = S_DRIVE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign table_out = table_q;
  assign fail_cnt  = fail_cnt_q;
`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
  assign fail_idx  = fail_idx_q;
`endif

endmodule
